// File: rtl/bcd_addsub_serial.sv
// Digit-serial N-digit BCD adder/subtractor: one digit per clock, LSB first,
// with a start/busy/done handshake and invalid-digit detection.
module bcd_addsub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   s,
    output logic                  co,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, digit}; subtraction adds the nine's complement of b.
    function automatic logic [4:0] digit_step(input logic [3:0] ad,
                                              input logic [3:0] bd_raw,
                                              input logic       subtract,
                                              input logic       carry);
        logic [3:0] bd;
        logic [4:0] t;
        logic [3:0] adj;
        bd  = subtract ? (4'd9 - bd_raw) : bd_raw;
        t   = {1'b0, ad} + {1'b0, bd} + {4'd0, carry};
        adj = t[3:0] + 4'd6;
        if (t > 5'd9) begin
            digit_step = {1'b1, adj};
        end else begin
            digit_step = {1'b0, t[3:0]};
        end
    endfunction

    function automatic logic has_bad_digit(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        has_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            has_bad_digit = has_bad_digit | (x[4*i +: 4] > 4'd9) | (y[4*i +: 4] > 4'd9);
        end
    endfunction

    state_t         state_r, state_next_s;
    logic           accept_s, last_s;
    logic [4:0]     step_s;
    logic [W-1:0]   acc_next_s;
    logic [W-1:0]   a_r, b_r, acc_r, s_r;
    logic           sub_r, carry_r, err_flag_r;
    logic [CW-1:0]  cnt_r;
    logic           busy_r, done_r, co_r, err_r;

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign co   = co_r;
    assign err  = err_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; DONE accepts a new start just like IDLE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Current digit sum; the result shifts in from the top so digit 0 ends at the bottom.
    always_comb begin
        step_s     = digit_step(a_r[3:0], b_r[3:0], sub_r, carry_r);
        acc_next_s = (acc_r >> 4) | (W'(step_s[3:0]) << (W - 4));
    end

    // Operand capture, digit iteration and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            acc_r      <= {W{1'b0}};
            s_r        <= {W{1'b0}};
            sub_r      <= 1'b0;
            carry_r    <= 1'b0;
            err_flag_r <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            co_r       <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            busy_r <= (state_next_s == RUN);
            done_r <= (state_next_s == DONE);
            if (accept_s) begin
                a_r        <= a;
                b_r        <= b;
                sub_r      <= sub;
                carry_r    <= sub ? ~cin : cin;
                err_flag_r <= has_bad_digit(a, b);
                cnt_r      <= {CW{1'b0}};
                acc_r      <= {W{1'b0}};
            end else if (state_r == RUN) begin
                a_r     <= a_r >> 4;
                b_r     <= b_r >> 4;
                carry_r <= step_s[4];
                cnt_r   <= cnt_r + CW'(1);
                acc_r   <= acc_next_s;
                if (last_s) begin
                    s_r   <= err_flag_r ? {W{1'b0}} : acc_next_s;
                    co_r  <= err_flag_r ? 1'b0 : (sub_r ? ~step_s[4] : step_s[4]);
                    err_r <= err_flag_r;
                end
            end
        end
    end

endmodule

// File: doc/bcd_addsub_serial.md
Name: bcd_addsub_serial

Overview:
- Digit-serial, parametrised N-digit BCD adder/subtractor with a start/busy/done handshake.
- Processes one BCD digit per clock, LSB digit first, and adds subtract mode plus invalid-digit detection.
- Successor to the fixed 4-digit combinational BCD adder; used where wide decimal operands make a flat ripple chain too slow or too large.

Parameters:
DIGITS, 4, number of BCD digits per operand (legal range 1..16); operand width is 4*DIGITS.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request a new operation; sampled only when busy=0
sub  input  1  0 = add, 1 = subtract; captured on accepted start
a  input  4*DIGITS  operand A; digit i at bits [4i+3:4i]; captured on accepted start
b  input  4*DIGITS  operand B; same packing; captured on accepted start
cin  input  1  carry-in (add) or borrow-in (sub); captured on accepted start
busy  output  1  high while digits are being processed
done  output  1  one-cycle pulse when s/co/err are updated
s  output  4*DIGITS  BCD result
co  output  1  decimal carry-out (add) or borrow-out (sub)
err  output  1  an operand digit was greater than 9

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - busy, done, s, co and err all go to 0.
  - Internal digit counter and carry go to 0.
  - Reset overrides any operation in progress; the partial result is discarded and s is not updated.
- State machine:
  - IDLE: busy=0. start=1 captures a, b, sub and cin, clears the digit counter, sets internal carry (cin if add, ~cin if sub), and moves to RUN.
  - RUN: busy=1. Each edge processes digit k (k = counter) and increments the counter. The edge that processes digit DIGITS-1 moves to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation). Otherwise the block returns to IDLE.
- start while busy=1 is ignored; the operands in flight are unaffected.
- Latency: start sampled at edge 0; done=1 and s/co/err valid after edge DIGITS. Throughput is one operation per DIGITS+1 cycles.
- Digit step:
  - Effective B digit: bd = b_k if add, 9 - b_k if sub (nine's complement).
  - t = a_k + bd + carry, computed 5 bits wide.
  - If t > 9: digit = t + 6 (low 4 bits), carry = 1. Otherwise digit = t, carry = 0.
- Result rules:
  - Add: s = (A + B + cin) mod 10^DIGITS; co = final carry.
  - Sub: s = (A - B - cin) mod 10^DIGITS, i.e. ten's complement on underflow; co = ~final carry, so 1 means a borrow occurred.
- Invalid digits:
  - On an accepted start, any nibble of a or b greater than 9 sets an internal error flag.
  - The operation still takes the full DIGITS cycles.
  - At done: err=1, s=0, co=0.
  - err is cleared at the done of the next valid operation.
- Output holding: s, co and err update only on the edge that asserts done; they hold their previous values during RUN and IDLE.
- Widths: no truncation beyond mod 10^DIGITS; the digit counter is clog2(DIGITS) bits, minimum 1.

Test Plan:
- Add, DIGITS=4: a=0x1234, b=0x5678, cin=0, sub=0 -> after 4 cycles s=0x6912, co=0, err=0, single-cycle done, busy high for exactly 4 cycles.
- Add wrap: a=0x9999, b=0x0001, cin=0 -> s=0x0000, co=1. Repeat with a=0x9999, b=0x0000, cin=1 -> s=0x0000, co=1.
- Subtract: a=0x0100, b=0x0001, sub=1, cin=0 -> s=0x0099, co=0. Then a=0x0000, b=0x0001, sub=1 -> s=0x9999, co=1. Then a=0x0005, b=0x0003, sub=1, cin=1 -> s=0x0001, co=0.
- Invalid digit: a=0x12A4, b=0x0001 -> done after 4 cycles with err=1, s=0, co=0. A following valid 0x0001+0x0001 -> s=0x0002, err=0.
- Handshake:
  - start pulsed again mid-RUN with different operands -> ignored; the original result is produced.
  - start held high through the DONE cycle -> second operation begins immediately; its done arrives 5 cycles after the first done.
- Reset mid-operation: rst_n=0 for one edge during RUN -> busy=0, done=0, s=0, co=0, err=0; no done pulse follows. Also run random valid operands at DIGITS=1 and DIGITS=8 against a decimal reference model.
